// File: rtl/pop_count_pkg.sv
// Shared defaults and arithmetic helpers for the pipelined population counter.
package pop_count_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int DEF_ACC_W = 16;

    typedef struct packed {
        logic        ovf;
        logic [63:0] val;
    } sat_res_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Unsigned add clamped to 2^w-1; w must stay below 64.
    function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                         input int unsigned w);
        sat_res_t    r;
        logic [64:0] s;
        logic [63:0] maxv;
        maxv = (64'd1 << w) - 64'd1;
        s    = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, maxv}) begin
            r.ovf = 1'b1;
            r.val = maxv;
        end else begin
            r.ovf = 1'b0;
            r.val = s[63:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pop_count_chunk.sv
// Combinational popcount of one CHUNK-bit slice; small enough to map into LUTs.
module pop_count_chunk
    import pop_count_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0]                 i_bits,
    output logic [cnt_width(CHUNK)-1:0]      o_cnt
);

    localparam int CW = cnt_width(CHUNK);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_cnt = o_cnt + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/pop_count_pipe.sv
// Three-stage popcount pipeline (capture, slice count, sum + burst accumulate)
// behind a valid/ready stream with a single global stall.
module pop_count_pipe
    import pop_count_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            bin,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [cnt_width(WIDTH)-1:0] out,
    output logic [ACC_W-1:0]            acc,
    output logic                        acc_sat,
    output logic                        out_last
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CW    = cnt_width(CHUNK);

    logic w_advance;

    assign w_advance = !(out_valid && !out_ready);
    assign in_ready  = w_advance && !rst;

    // ---- S1: capture word ----
    logic             r_vld_p1;
    logic             r_last_p1;
    logic [WIDTH-1:0] r_bin_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_advance) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_bin_p1  <= bin;
            r_last_p1 <= in_last;
        end
    end

    // ---- S2: per-slice counts ----
    logic [CW-1:0] w_cnt    [NCH];
    logic [CW-1:0] r_cnt_p2 [NCH];
    logic          r_vld_p2;
    logic          r_last_p2;

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        pop_count_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_bits (r_bin_p1[g*CHUNK +: CHUNK]),
            .o_cnt  (w_cnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
        end else if (w_advance) begin
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_last_p2 <= r_last_p1;
            for (int i = 0; i < NCH; i++) begin
                r_cnt_p2[i] <= w_cnt[i];
            end
        end
    end

    // ---- S3: word sum, burst accumulation, output register ----
    logic [CNT_W-1:0] w_sum;
    logic [ACC_W-1:0] r_acc_run;
    logic             r_acc_sat_run;
    sat_res_t         w_sat;
    logic [ACC_W-1:0] w_next;
    logic             w_sat_next;
    logic             w_unused_sat_hi;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = w_sum + CNT_W'(r_cnt_p2[i]);
        end
    end

    assign w_sat           = sat_add(64'(r_acc_run), 64'(w_sum), ACC_W);
    assign w_next          = w_sat.val[ACC_W-1:0];
    assign w_sat_next      = r_acc_sat_run | w_sat.ovf;
    assign w_unused_sat_hi = ^w_sat.val[63:ACC_W];

    // The running total restarts at zero on the edge that emits a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out           <= '0;
            acc           <= '0;
            acc_sat       <= 1'b0;
            out_last      <= 1'b0;
            r_acc_run     <= '0;
            r_acc_sat_run <= 1'b0;
        end else if (w_advance) begin
            out_valid <= r_vld_p2;
            if (r_vld_p2) begin
                out      <= w_sum;
                acc      <= w_next;
                acc_sat  <= w_sat_next;
                out_last <= r_last_p2;
                if (r_last_p2) begin
                    r_acc_run     <= '0;
                    r_acc_sat_run <= 1'b0;
                end else begin
                    r_acc_run     <= w_next;
                    r_acc_sat_run <= w_sat_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pop_count_pipe.sv
// Bench for pop_count_pipe: directed scenarios on 32/8/16 and 32/8/8 instances,
// randomized traffic on 64/4/16 and 16/8/8 instances against a behavioural model.
module tb_pop_count_pipe;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [15:0] acc;
        logic        sat;
        logic        last;
    } res_t;

    localparam int WID  [4] = '{32, 32, 64, 16};
    localparam int ACCW [4] = '{16, 8, 16, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d       [4];
    logic        in_valid_d  [4];
    logic [63:0] bin_d       [4];
    logic        in_last_d   [4];
    logic        out_ready_d [4];
    wire         in_ready_d  [4];
    wire         out_valid_d [4];
    wire  [7:0]  out_d       [4];
    wire  [15:0] acc_d       [4];
    wire         sat_d       [4];
    wire         last_d      [4];

    wire [5:0]  out0, out1;
    wire [6:0]  out2;
    wire [4:0]  out3;
    wire [15:0] acc0, acc2;
    wire [7:0]  acc1, acc3;

    assign out_d[0] = {2'd0, out0};
    assign out_d[1] = {2'd0, out1};
    assign out_d[2] = {1'd0, out2};
    assign out_d[3] = {3'd0, out3};
    assign acc_d[0] = acc0;
    assign acc_d[1] = {8'd0, acc1};
    assign acc_d[2] = acc2;
    assign acc_d[3] = {8'd0, acc3};

    pop_count_pipe #(.WIDTH(32), .CHUNK(8), .ACC_W(16)) u_dut0 (
        .clk(clk), .rst(rst_d[0]), .in_valid(in_valid_d[0]), .in_ready(in_ready_d[0]),
        .bin(bin_d[0][31:0]), .in_last(in_last_d[0]), .out_valid(out_valid_d[0]),
        .out_ready(out_ready_d[0]), .out(out0), .acc(acc0), .acc_sat(sat_d[0]),
        .out_last(last_d[0])
    );

    pop_count_pipe #(.WIDTH(32), .CHUNK(8), .ACC_W(8)) u_dut1 (
        .clk(clk), .rst(rst_d[1]), .in_valid(in_valid_d[1]), .in_ready(in_ready_d[1]),
        .bin(bin_d[1][31:0]), .in_last(in_last_d[1]), .out_valid(out_valid_d[1]),
        .out_ready(out_ready_d[1]), .out(out1), .acc(acc1), .acc_sat(sat_d[1]),
        .out_last(last_d[1])
    );

    pop_count_pipe #(.WIDTH(64), .CHUNK(4), .ACC_W(16)) u_dut2 (
        .clk(clk), .rst(rst_d[2]), .in_valid(in_valid_d[2]), .in_ready(in_ready_d[2]),
        .bin(bin_d[2]), .in_last(in_last_d[2]), .out_valid(out_valid_d[2]),
        .out_ready(out_ready_d[2]), .out(out2), .acc(acc2), .acc_sat(sat_d[2]),
        .out_last(last_d[2])
    );

    pop_count_pipe #(.WIDTH(16), .CHUNK(8), .ACC_W(8)) u_dut3 (
        .clk(clk), .rst(rst_d[3]), .in_valid(in_valid_d[3]), .in_ready(in_ready_d[3]),
        .bin(bin_d[3][15:0]), .in_last(in_last_d[3]), .out_valid(out_valid_d[3]),
        .out_ready(out_ready_d[3]), .out(out3), .acc(acc3), .acc_sat(sat_d[3]),
        .out_last(last_d[3])
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_run;
    logic m_sat;
    res_t exp_q [$];
    res_t got_q [$];

    function automatic logic [63:0] wmask(input int d);
        return (WID[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << WID[d]) - 64'd1);
    endfunction

    // Reference: each beat adds its popcount to the burst total, clamped at 2^ACC_W-1.
    task automatic model_push(input int d, input logic [63:0] w, input logic l);
        int   c;
        int   nxt;
        int   maxv;
        logic s;
        res_t r;
        c    = $countones(w);
        maxv = (1 << ACCW[d]) - 1;
        nxt  = m_run + c;
        s    = 1'b0;
        if (nxt > maxv) begin
            nxt = maxv;
            s   = 1'b1;
        end
        r.cnt  = 8'(c);
        r.acc  = 16'(nxt);
        r.sat  = m_sat | s;
        r.last = l;
        exp_q.push_back(r);
        if (l) begin
            m_run = 0;
            m_sat = 1'b0;
        end else begin
            m_run = nxt;
            m_sat = r.sat;
        end
    endtask

    // One clock: drive at the falling edge, observe what the next rising edge will transfer.
    task automatic cycle(input int d, input logic v, input logic [63:0] w, input logic l,
                         input logic ordy, output logic accepted);
        res_t g;
        @(negedge clk);
        in_valid_d[d]  = v;
        bin_d[d]       = w;
        in_last_d[d]   = l;
        out_ready_d[d] = ordy;
        #1;
        accepted = v && in_ready_d[d];
        if (accepted) model_push(d, w, l);
        if (out_valid_d[d] && ordy) begin
            g.cnt  = out_d[d];
            g.acc  = acc_d[d];
            g.sat  = sat_d[d];
            g.last = last_d[d];
            got_q.push_back(g);
        end
    endtask

    task automatic apply_reset(input int d, input int n);
        @(negedge clk);
        rst_d[d]       = 1'b1;
        in_valid_d[d]  = 1'b0;
        in_last_d[d]   = 1'b0;
        out_ready_d[d] = 1'b1;
        repeat (n) @(negedge clk);
        rst_d[d] = 1'b0;
        m_run    = 0;
        m_sat    = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_d[0]       = 1'b1;
        in_valid_d[0]  = 1'b1;
        bin_d[0]       = 64'hFFFF_FFFF;
        in_last_d[0]   = 1'b1;
        out_ready_d[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (in_ready_d[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_in_ready cycle %0d: got %0d expected 0", i, in_ready_d[0]);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid_d[0]);
        end
        n_checks++;
        if (out_d[0] !== 8'd0 || acc_d[0] !== 16'd0) begin
            n_fail++; $display("FAIL reset_data: got out=%0d acc=%0d expected 0 0", out_d[0], acc_d[0]);
        end
        n_checks++;
        if (sat_d[0] !== 1'b0 || last_d[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got sat=%0d last=%0d expected 0 0", sat_d[0], last_d[0]);
        end
        rst_d[0]      = 1'b0;
        in_valid_d[0] = 1'b0;
        m_run = 0; m_sat = 1'b0; exp_q.delete(); got_q.delete();
    endtask

    task automatic test_basic();
        logic ok;
        int   lat;
        lat = 0;
        cycle(0, 1'b1, 64'hFFFF_FFFF, 1'b1, 1'b1, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %0d expected 1", ok); end
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            cycle(0, 1'b0, 64'd0, 1'b0, 1'b1, ok);
            if (out_valid_d[0]) lat = i;
        end
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL basic_count: got %0d outputs expected 1", got_q.size());
        end else if (got_q[0] !== res_t'{8'd32, 16'd32, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_value: got out=%0d acc=%0d sat=%0d last=%0d expected 32 32 0 1",
                     got_q[0].cnt, got_q[0].acc, got_q[0].sat, got_q[0].last);
        end
        cycle(0, 1'b0, 64'd0, 1'b0, 1'b1, ok);
        n_checks++;
        if (out_valid_d[0] !== 1'b0 || out_d[0] !== 8'd32 || acc_d[0] !== 16'd32) begin
            n_fail++;
            $display("FAIL basic_after_transfer: got valid=%0d out=%0d acc=%0d expected 0 32 32",
                     out_valid_d[0], out_d[0], acc_d[0]);
        end
    endtask

    task automatic test_burst();
        logic [63:0] words  [4] = '{64'h0000_000F, 64'h00FF_0000, 64'h8000_0001, 64'h0000_0003};
        logic        lasts  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int          e_out  [4] = '{4, 8, 2, 2};
        int          e_acc  [4] = '{4, 12, 14, 2};
        logic        ok;
        apply_reset(0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1'b1, words[i], lasts[i], 1'b1, ok);
            n_checks++;
            if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_accept %0d: got %0d expected 1", i, ok); end
        end
        for (int i = 0; i < 10 && got_q.size() < 4; i++) cycle(0, 1'b0, 64'd0, 1'b0, 1'b1, ok);
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++; $display("FAIL burst_count: got %0d outputs expected 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== res_t'{8'(e_out[i]), 16'(e_acc[i]), 1'b0, lasts[i]}) begin
                n_fail++;
                $display("FAIL burst_beat %0d: got out=%0d acc=%0d sat=%0d last=%0d expected %0d %0d 0 %0d",
                         i, got_q[i].cnt, got_q[i].acc, got_q[i].sat, got_q[i].last,
                         e_out[i], e_acc[i], lasts[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] words [6] = '{64'h1, 64'h3, 64'h7, 64'hF, 64'h1F, 64'h3F};
        int          e_acc [6] = '{1, 3, 6, 10, 15, 21};
        int          wi;
        int          stall;
        logic        started;
        logic        ok;
        logic        ordy;
        wi = 0; stall = 0; started = 1'b0;
        apply_reset(0, 1);
        for (int cyc = 0; cyc < 40 && got_q.size() < 6; cyc++) begin
            ordy = (stall == 0);
            cycle(0, wi < 6, (wi < 6) ? words[wi] : 64'd0, wi == 5, ordy, ok);
            if (ok) wi++;
            if (!ordy) begin
                n_checks++;
                if (in_ready_d[0] !== 1'b0 || out_valid_d[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_handshake: got in_ready=%0d out_valid=%0d expected 0 1",
                             in_ready_d[0], out_valid_d[0]);
                end
                n_checks++;
                if (out_d[0] !== 8'd2 || acc_d[0] !== 16'd3) begin
                    n_fail++;
                    $display("FAIL stall_hold: got out=%0d acc=%0d expected 2 3", out_d[0], acc_d[0]);
                end
                stall--;
            end else if (!started && got_q.size() == 1) begin
                started = 1'b1;
                stall   = 5;
            end
        end
        n_checks++;
        if (got_q.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d outputs expected 6", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            n_checks++;
            if (got_q[i] !== res_t'{8'(i + 1), 16'(e_acc[i]), 1'b0, i == 5}) begin
                n_fail++;
                $display("FAIL bp_beat %0d: got out=%0d acc=%0d last=%0d expected %0d %0d %0d",
                         i, got_q[i].cnt, got_q[i].acc, got_q[i].last, i + 1, e_acc[i], i == 5);
            end
        end
    endtask

    task automatic test_saturation();
        int   e_acc [10] = '{32, 64, 96, 128, 160, 192, 224, 255, 255, 32};
        logic e_sat [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        logic ok;
        apply_reset(1, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1'b1, 64'hFFFF_FFFF, (i >= 8), 1'b1, ok);
            n_checks++;
            if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_accept %0d: got %0d expected 1", i, ok); end
        end
        for (int i = 0; i < 10 && got_q.size() < 10; i++) cycle(1, 1'b0, 64'd0, 1'b0, 1'b1, ok);
        n_checks++;
        if (got_q.size() != 10) begin
            n_fail++; $display("FAIL sat_count: got %0d outputs expected 10", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            n_checks++;
            if (got_q[i].cnt !== 8'd32 || got_q[i].acc !== 16'(e_acc[i]) || got_q[i].sat !== e_sat[i]) begin
                n_fail++;
                $display("FAIL sat_beat %0d: got out=%0d acc=%0d sat=%0d expected 32 %0d %0d",
                         i, got_q[i].cnt, got_q[i].acc, got_q[i].sat, e_acc[i], e_sat[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic ok;
        apply_reset(0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1'b1, 64'hFF, 1'b0, 1'b0, ok);
            n_checks++;
            if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_accept %0d: got %0d expected 1", i, ok); end
        end
        @(negedge clk);
        rst_d[0]      = 1'b1;
        in_valid_d[0] = 1'b0;
        #1;
        n_checks++;
        if (in_ready_d[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrst_in_ready: got %0d expected 0", in_ready_d[0]);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flush: got out_valid=%0d expected 0", out_valid_d[0]);
        end
        rst_d[0] = 1'b0;
        m_run = 0; m_sat = 1'b0; exp_q.delete(); got_q.delete();
        cycle(0, 1'b1, 64'h1, 1'b1, 1'b1, ok);
        for (int i = 0; i < 8; i++) cycle(0, 1'b0, 64'd0, 1'b0, 1'b1, ok);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL midrst_count: got %0d outputs expected 1", got_q.size());
        end else if (got_q[0] !== res_t'{8'd1, 16'd1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_value: got out=%0d acc=%0d sat=%0d last=%0d expected 1 1 0 1",
                     got_q[0].cnt, got_q[0].acc, got_q[0].sat, got_q[0].last);
        end
    endtask

    task automatic test_sweep(input int d, input int ncyc, input int last_mod);
        logic        ok;
        logic        v;
        logic        l;
        logic        ordy;
        logic [63:0] w;
        res_t        g;
        res_t        e;
        apply_reset(d, 1);
        for (int cyc = 0; cyc < ncyc + 30; cyc++) begin
            if (cyc < ncyc) begin
                v    = ($urandom_range(3) != 0);
                w    = {$urandom, $urandom} & wmask(d);
                l    = ($urandom_range(last_mod - 1) == 0);
                ordy = ($urandom_range(3) != 0);
            end else begin
                v = 1'b0; w = 64'd0; l = 1'b0; ordy = 1'b1;
            end
            cycle(d, v, w, l, ordy, ok);
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep%0d_extra: got out=%0d acc=%0d with no word pending", d, g.cnt, g.acc);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL sweep%0d_beat: got out=%0d acc=%0d sat=%0d last=%0d expected %0d %0d %0d %0d",
                                 d, g.cnt, g.acc, g.sat, g.last, e.cnt, e.acc, e.sat, e.last);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sweep%0d_missing: got %0d words undelivered expected 0", d, exp_q.size());
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            rst_d[d]       = 1'b0;
            in_valid_d[d]  = 1'b0;
            bin_d[d]       = 64'd0;
            in_last_d[d]   = 1'b0;
            out_ready_d[d] = 1'b1;
        end
        m_run = 0;
        m_sat = 1'b0;
        test_reset();
        test_basic();
        test_burst();
        test_backpressure();
        test_saturation();
        test_reset_mid_burst();
        test_sweep(2, 500, 12);
        test_sweep(3, 500, 40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
